// File: rtl/sound_mixer_pkg.sv
// sound_mixer_pkg: shared IO register addresses, sample width and mixer FSM states
package sound_mixer_pkg;
   localparam logic [15:0] NR50_DEF = 16'hFF24;
   localparam logic [15:0] NR51_DEF = 16'hFF25;
   localparam logic [15:0] NR52_DEF = 16'hFF26;
   localparam int SAMPLE_W = 20;
   typedef enum logic [2:0] {IDLE, ACC1, ACC2, ACC3, ACC4, SCALE, OUT} mix_state_t;
endpackage

// File: rtl/sound_mix_path.sv
// sound_mix_path: one output side's channel accumulator and volume scaler
module sound_mix_path
   import sound_mixer_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                add_en,
   input  logic                scale_en,
   input  logic [SAMPLE_W-1:0] add_val,
   input  logic [2:0]          vol,
   output logic [SAMPLE_W-2:0] result
);
   logic [SAMPLE_W:0] acc;
   logic [23:0]       prod;
   assign prod = {3'b0, acc} * {20'b0, {1'b0, vol} + 4'd1};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         result <= '0;
      end else begin
         acc <= clear ? '0 : acc + (add_en ? {1'b0, add_val} : '0);
         // divide by 8 for the volume range, then by 4 for the four-channel headroom
         if (scale_en) result <= (SAMPLE_W-1)'((prod >> 3) >> 2);
      end
   end
endmodule

// File: rtl/sound_mixer.sv
// sound_mixer: NR50/NR51/NR52 register block and a sequenced four-channel
// stereo mixer producing one left/right sample pair per accepted strobe
module sound_mixer
   import sound_mixer_pkg::*;
#(
   parameter logic [15:0] NR50_ADDR = NR50_DEF,
   parameter logic [15:0] NR51_ADDR = NR51_DEF,
   parameter logic [15:0] NR52_ADDR = NR52_DEF
) (
   input  logic                I_CLK,
   input  logic                I_RESET,
   input  logic                I_STROBE,
   input  logic [15:0]         I_IOREG_ADDR,
   inout  wire  [7:0]          IO_IOREG_DATA,
   input  logic                I_IOREG_WE_L,
   input  logic                I_IOREG_RE_L,
   input  logic [SAMPLE_W-1:0] I_CH1_WAVEFORM,
   input  logic [SAMPLE_W-1:0] I_CH2_WAVEFORM,
   input  logic [SAMPLE_W-1:0] I_CH3_WAVEFORM,
   input  logic [SAMPLE_W-1:0] I_CH4_WAVEFORM,
   input  logic                I_CH1_ON,
   input  logic                I_CH2_ON,
   input  logic                I_CH3_ON,
   input  logic                I_CH4_ON,
   output logic [SAMPLE_W-1:0] O_LEFT_SAMPLE,
   output logic [SAMPLE_W-1:0] O_RIGHT_SAMPLE,
   output logic                O_SAMPLE_VALID,
   output logic                O_SOUND_EN
);
   logic [7:0]          nr50, nr51, lat_nr51, rd_data;
   logic [2:0]          lat_vl, lat_vr;
   logic                master_en, en_next, we50, we51, we52, hit, acc_phase, start;
   logic [1:0]          idx;
   logic [SAMPLE_W-1:0] lat_ch [4];
   logic [SAMPLE_W-2:0] res_l, res_r;
   mix_state_t          state;
   assign we50 = !I_IOREG_WE_L && I_IOREG_ADDR == NR50_ADDR;
   assign we51 = !I_IOREG_WE_L && I_IOREG_ADDR == NR51_ADDR;
   assign we52 = !I_IOREG_WE_L && I_IOREG_ADDR == NR52_ADDR;
   // the enable as it will be after this edge, so a disabling write aborts at once
   assign en_next = we52 ? IO_IOREG_DATA[7] : master_en;
   assign hit = I_IOREG_ADDR == NR50_ADDR || I_IOREG_ADDR == NR51_ADDR || I_IOREG_ADDR == NR52_ADDR;
   assign rd_data = I_IOREG_ADDR == NR50_ADDR ? nr50 :
                    I_IOREG_ADDR == NR51_ADDR ? nr51 :
                    {master_en, 3'b111, I_CH4_ON, I_CH3_ON, I_CH2_ON, I_CH1_ON};
   assign IO_IOREG_DATA = (!I_IOREG_RE_L && hit) ? rd_data : 8'hzz;
   assign O_SOUND_EN = master_en;
   assign acc_phase = state inside {ACC1, ACC2, ACC3, ACC4};
   assign idx = state == ACC2 ? 2'd1 : state == ACC3 ? 2'd2 : state == ACC4 ? 2'd3 : 2'd0;
   assign start = state == IDLE && I_STROBE && en_next;
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         nr50      <= '0;
         nr51      <= '0;
         master_en <= 1'b0;
      end else begin
         master_en <= en_next;
         if (!en_next) begin
            nr50 <= '0;
            nr51 <= '0;
         end else begin
            if (we50) nr50 <= IO_IOREG_DATA;
            if (we51) nr51 <= IO_IOREG_DATA;
         end
      end
   end
   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         state          <= IDLE;
         lat_nr51       <= '0;
         lat_vl         <= '0;
         lat_vr         <= '0;
         lat_ch         <= '{default: '0};
         O_LEFT_SAMPLE  <= '0;
         O_RIGHT_SAMPLE <= '0;
         O_SAMPLE_VALID <= 1'b0;
      end else begin
         O_SAMPLE_VALID <= 1'b0;
         if (!en_next) begin
            state          <= IDLE;
            O_LEFT_SAMPLE  <= '0;
            O_RIGHT_SAMPLE <= '0;
         end else if (state == IDLE) begin
            if (I_STROBE) begin
               state    <= ACC1;
               lat_nr51 <= nr51;
               lat_vl   <= nr50[6:4];
               lat_vr   <= nr50[2:0];
               lat_ch   <= '{I_CH1_WAVEFORM, I_CH2_WAVEFORM, I_CH3_WAVEFORM, I_CH4_WAVEFORM};
            end
         end else if (state == OUT) begin
            state          <= IDLE;
            O_LEFT_SAMPLE  <= {1'b0, res_l};
            O_RIGHT_SAMPLE <= {1'b0, res_r};
            O_SAMPLE_VALID <= 1'b1;
         end else begin
            state <= mix_state_t'(state + 3'd1);
         end
      end
   end
   sound_mix_path u_left (
      .clk(I_CLK), .rst(I_RESET), .clear(start),
      .add_en(acc_phase && lat_nr51[{1'b1, idx}]), .scale_en(state == SCALE),
      .add_val(lat_ch[idx]), .vol(lat_vl), .result(res_l)
   );
   sound_mix_path u_right (
      .clk(I_CLK), .rst(I_RESET), .clear(start),
      .add_en(acc_phase && lat_nr51[{1'b0, idx}]), .scale_en(state == SCALE),
      .add_val(lat_ch[idx]), .vol(lat_vr), .result(res_r)
   );
endmodule

// File: tb/tb_sound_mixer.sv
// tb_sound_mixer: directed and randomized checks of sound_mixer against a
// sample-level reference model of the register block and mix arithmetic
module tb_sound_mixer;
   logic        I_CLK = 0, I_RESET = 1, I_STROBE = 0;
   logic [15:0] I_IOREG_ADDR = 16'h0;
   logic        I_IOREG_WE_L = 1, I_IOREG_RE_L = 1;
   logic [19:0] ch1 = 0, ch2 = 0, ch3 = 0, ch4 = 0;
   logic        on1 = 0, on2 = 0, on3 = 0, on4 = 0;
   logic [19:0] O_LEFT_SAMPLE, O_RIGHT_SAMPLE;
   logic        O_SAMPLE_VALID, O_SOUND_EN;
   logic [7:0]  drv = 0;
   logic        drv_en = 0;
   wire  [7:0]  bus;
   assign bus = drv_en ? drv : 8'hzz;
   int checks = 0, errors = 0, vcount = 0;
   bit chk_on = 0;

   sound_mixer dut (
      .I_CLK(I_CLK), .I_RESET(I_RESET), .I_STROBE(I_STROBE), .I_IOREG_ADDR(I_IOREG_ADDR),
      .IO_IOREG_DATA(bus), .I_IOREG_WE_L(I_IOREG_WE_L), .I_IOREG_RE_L(I_IOREG_RE_L),
      .I_CH1_WAVEFORM(ch1), .I_CH2_WAVEFORM(ch2), .I_CH3_WAVEFORM(ch3), .I_CH4_WAVEFORM(ch4),
      .I_CH1_ON(on1), .I_CH2_ON(on2), .I_CH3_ON(on3), .I_CH4_ON(on4),
      .O_LEFT_SAMPLE(O_LEFT_SAMPLE), .O_RIGHT_SAMPLE(O_RIGHT_SAMPLE),
      .O_SAMPLE_VALID(O_SAMPLE_VALID), .O_SOUND_EN(O_SOUND_EN)
   );

   always #5 I_CLK = ~I_CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: a sample leaves exactly six clocks after an accepted strobe
   logic [7:0]  m_nr50 = 0, m_nr51 = 0;
   logic        m_en = 0, m_v = 0;
   logic [19:0] m_l = 0, m_r = 0, pl = 0, pr = 0;
   int          cnt = 0;
   logic        nx_en;
   assign nx_en = (!I_IOREG_WE_L && I_IOREG_ADDR == 16'hFF26) ? drv[7] : m_en;

   function automatic logic [19:0] mix(input logic [3:0] sel, input logic [2:0] v);
      longint s = 0;
      if (sel[0]) s += longint'(ch1);
      if (sel[1]) s += longint'(ch2);
      if (sel[2]) s += longint'(ch3);
      if (sel[3]) s += longint'(ch4);
      return 20'((s * (longint'(v) + 1)) / 32);
   endfunction

   always @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         m_nr50 <= 0; m_nr51 <= 0; m_en <= 0; m_v <= 0; m_l <= 0; m_r <= 0; cnt <= 0;
      end else begin
         m_en <= nx_en;
         m_v  <= 0;
         if (!nx_en) begin
            m_nr50 <= 0; m_nr51 <= 0; cnt <= 0; m_l <= 0; m_r <= 0;
         end else begin
            if (!I_IOREG_WE_L && I_IOREG_ADDR == 16'hFF24) m_nr50 <= drv;
            if (!I_IOREG_WE_L && I_IOREG_ADDR == 16'hFF25) m_nr51 <= drv;
            if (cnt > 0) begin
               cnt <= cnt - 1;
               if (cnt == 1) begin m_l <= pl; m_r <= pr; m_v <= 1; end
            end else if (I_STROBE) begin
               cnt <= 6;
               pl  <= mix(m_nr51[7:4], m_nr50[6:4]);
               pr  <= mix(m_nr51[3:0], m_nr50[2:0]);
            end
         end
      end
   end

   always @(negedge I_CLK) begin
      if (O_SAMPLE_VALID === 1'b1) vcount++;
      if (chk_on && !I_RESET) begin
         chk("valid", {31'b0, O_SAMPLE_VALID}, {31'b0, m_v});
         chk("left", {12'b0, O_LEFT_SAMPLE}, {12'b0, m_l});
         chk("right", {12'b0, O_RIGHT_SAMPLE}, {12'b0, m_r});
         chk("sound_en", {31'b0, O_SOUND_EN}, {31'b0, m_en});
      end
   end

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      I_IOREG_ADDR = a; drv = d; drv_en = 1; I_IOREG_WE_L = 0;
      @(posedge I_CLK); #1;
      I_IOREG_WE_L = 1; drv_en = 0;
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string name);
      I_IOREG_ADDR = a; I_IOREG_RE_L = 0;
      #1 chk(name, {24'b0, bus}, {24'b0, exp});
      I_IOREG_RE_L = 1;
   endtask

   task automatic strobe();
      I_STROBE = 1;
      @(posedge I_CLK); #1;
      I_STROBE = 0;
   endtask

   task automatic wait_valid(output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge I_CLK); #1;
         if (O_SAMPLE_VALID) begin lat = k; break; end
      end
   endtask

   int lat, v0;
   logic [15:0] ra;
   initial begin
      repeat (2) @(posedge I_CLK);
      #1 I_RESET = 0;
      chk("reset_left", {12'b0, O_LEFT_SAMPLE}, 32'h0);
      chk("reset_right", {12'b0, O_RIGHT_SAMPLE}, 32'h0);
      chk("reset_en", {31'b0, O_SOUND_EN}, 32'h0);
      chk_on = 1;
      // disabled after reset: strobe ignored
      v0 = vcount; strobe(); repeat (10) @(posedge I_CLK); #1;
      chk("strobe_while_off", vcount - v0, 0);
      wr(16'hFF26, 8'h80);
      on3 = 1;
      rd(16'hFF26, 8'hF4, "nr52_read");
      on3 = 0;
      wr(16'hFF25, 8'h11); wr(16'hFF24, 8'h77);
      rd(16'hFF24, 8'h77, "nr50_read");
      ch1 = 20'h7FFFF; ch2 = 0; ch3 = 0; ch4 = 0;
      strobe(); wait_valid(lat);
      chk("latency", lat, 6);
      chk("ch1_left", {12'b0, O_LEFT_SAMPLE}, 32'h1FFFF);
      chk("ch1_right", {12'b0, O_RIGHT_SAMPLE}, 32'h1FFFF);
      @(posedge I_CLK); #1;
      chk("valid_one_cycle", {31'b0, O_SAMPLE_VALID}, 32'h0);
      chk("hold_left", {12'b0, O_LEFT_SAMPLE}, 32'h1FFFF);
      ch1 = 20'h7FFFF; ch2 = 20'h7FFFF; ch3 = 20'h7FFFF; ch4 = 20'h7FFFF;
      wr(16'hFF25, 8'hF0); wr(16'hFF24, 8'h70);
      strobe(); wait_valid(lat);
      chk("full_left", {12'b0, O_LEFT_SAMPLE}, 32'h7FFFF);
      chk("full_right", {12'b0, O_RIGHT_SAMPLE}, 32'h0);
      wr(16'hFF24, 8'h30); wr(16'hFF25, 8'h10);
      ch1 = 20'h44443;
      v0 = vcount;
      strobe(); @(posedge I_CLK); #1; strobe();
      repeat (12) @(posedge I_CLK); #1;
      chk("one_pulse", vcount - v0, 1);
      chk("vl3_left", {12'b0, O_LEFT_SAMPLE}, 32'h08888);
      // disable during ACC2
      wr(16'hFF24, 8'h77); wr(16'hFF25, 8'h11);
      v0 = vcount;
      strobe(); @(posedge I_CLK); #1; wr(16'hFF26, 8'h00);
      repeat (10) @(posedge I_CLK); #1;
      chk("abort_no_valid", vcount - v0, 0);
      chk("abort_left", {12'b0, O_LEFT_SAMPLE}, 32'h0);
      rd(16'hFF24, 8'h00, "off_nr50");
      rd(16'hFF25, 8'h00, "off_nr51");
      wr(16'hFF24, 8'h55);
      rd(16'hFF24, 8'h00, "off_write_ignored");
      // reset mid-mix after a completed sample
      wr(16'hFF26, 8'h80); wr(16'hFF25, 8'h11); wr(16'hFF24, 8'h77);
      ch1 = 20'h7FFFF;
      strobe(); wait_valid(lat);
      chk("pre_reset_left", {12'b0, O_LEFT_SAMPLE}, 32'h1FFFF);
      strobe(); @(posedge I_CLK); #1;
      I_RESET = 1;
      #1;
      chk("async_left", {12'b0, O_LEFT_SAMPLE}, 32'h0);
      chk("async_right", {12'b0, O_RIGHT_SAMPLE}, 32'h0);
      chk("async_en", {31'b0, O_SOUND_EN}, 32'h0);
      repeat (2) @(posedge I_CLK); #1;
      I_RESET = 0;
      rd(16'hFF25, 8'h00, "post_reset_nr51");
      v0 = vcount; strobe(); repeat (10) @(posedge I_CLK); #1;
      chk("post_reset_strobe", vcount - v0, 0);
      // randomized traffic
      wr(16'hFF26, 8'h80);
      for (int i = 0; i < 3000; i++) begin
         ch1 = 20'($urandom) & 20'h7FFFF; ch2 = 20'($urandom) & 20'h7FFFF;
         ch3 = 20'($urandom) & 20'h7FFFF; ch4 = 20'($urandom) & 20'h7FFFF;
         {on1, on2, on3, on4} = 4'($urandom);
         I_STROBE = ($urandom % 3) == 0;
         ra = 16'hFF24 + 16'($urandom % 16);
         if (ra <= 16'hFF26) begin
            I_IOREG_ADDR = ra;
            drv = ra != 16'hFF26 ? 8'($urandom) : (($urandom % 8) == 0 ? 8'h00 : 8'h80);
            drv_en = 1; I_IOREG_WE_L = 0;
         end
         @(posedge I_CLK); #1;
         I_IOREG_WE_L = 1; drv_en = 0; I_STROBE = 0;
         if (($urandom % 6) == 0) begin
            case ($urandom % 3)
               0: rd(16'hFF24, m_nr50, "rand_nr50");
               1: rd(16'hFF25, m_nr51, "rand_nr51");
               default: rd(16'hFF26, {m_en, 3'b111, on4, on3, on2, on1}, "rand_nr52");
            endcase
         end
      end
      repeat (8) @(posedge I_CLK); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sound_mixer.md
SOUND_MIXER -- requirements
Module: sound_mixer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NR50_ADDR, 16'hFF24, master volume register address; NR51_ADDR, 16'hFF25, panning register address; NR52_ADDR, 16'hFF26, sound on/off register address.
REQ-002 I_CLK  in  1  sole clock; all logic on posedge.
REQ-003 I_RESET  in  1  asynchronous, active-high reset.
REQ-004 I_STROBE  in  1  one-cycle sample-request pulse, already synchronous to I_CLK.
REQ-005 I_IOREG_ADDR  in  16  IO register bus address.
REQ-006 IO_IOREG_DATA  inout  8  IO register bus data; high-Z unless this block is read.
REQ-007 I_IOREG_WE_L, I_IOREG_RE_L  in  1 each  active-low bus write / read.
REQ-008 I_CH1_WAVEFORM..I_CH4_WAVEFORM  in  20 each  unsigned channel samples, range 0..20'h7FFFF.
REQ-009 I_CH1_ON..I_CH4_ON  in  1 each  channel-active status.
REQ-010 O_LEFT_SAMPLE, O_RIGHT_SAMPLE  out  20 each  mixed output samples.
REQ-011 O_SAMPLE_VALID  out  1  one-cycle pulse when new samples are presented.
REQ-012 O_SOUND_EN  out  1  NR52 bit 7 (master enable).

Function
REQ-013 NR50 and NR51 SHALL be 8-bit R/W; write on the posedge where WE_L=0 and the address matches; read drives the stored value while RE_L=0.
REQ-014 NR52 reads SHALL return {master_en, 3'b111, CH4_ON, CH3_ON, CH2_ON, CH1_ON}; writes SHALL affect bit 7 only.
REQ-015 While master_en=0, NR50/NR51 SHALL be held at 0 and writes to them ignored; NR52 SHALL remain writable.
REQ-016 NR51 bits 7:4 SHALL enable CH4..CH1 into left; bits 3:0 SHALL enable CH4..CH1 into right.
REQ-017 NR50 bits 6:4 SHALL be left volume VL; bits 2:0 right volume VR; bits 7 and 3 are stored but unused.
REQ-018 FSM states: IDLE, ACC1, ACC2, ACC3, ACC4, SCALE, OUT.
REQ-019 IDLE->ACC1 on I_STROBE with master_en=1; on entry, clear 21-bit L/R accumulators and latch NR50/NR51 and all four waveforms.
REQ-020 ACCn SHALL add latched CHn to each accumulator whose NR51 enable bit is set; one channel per cycle.
REQ-021 SCALE SHALL compute acc*(V+1) (24-bit), >>3, then >>2, producing a 19-bit result zero-extended to 20 bits.
REQ-022 OUT SHALL register results into O_LEFT/O_RIGHT_SAMPLE, pulse O_SAMPLE_VALID, and return to IDLE; latency strobe-to-valid = 6 cycles.
REQ-023 I_STROBE arriving outside IDLE SHALL be ignored; no queueing.
REQ-024 Register writes during a mix SHALL NOT affect that mix; they affect the next strobe.
REQ-025 master_en cleared mid-mix SHALL abort to IDLE, force both outputs to 0, and suppress O_SAMPLE_VALID.
REQ-026 When master_en=0, outputs SHALL read 0 and strobes SHALL be ignored.
REQ-027 Outputs SHALL hold their last value between valid pulses.

Reset
REQ-028 I_RESET SHALL asynchronously clear NR50, NR51, master_en, accumulators, latched inputs, O_LEFT/O_RIGHT_SAMPLE, O_SAMPLE_VALID and O_SOUND_EN to 0, and force the FSM to IDLE, including mid-mix.
REQ-029 After reset deassertion, the first strobe SHALL be ignored unless NR52 bit 7 has been written to 1.

Structure
REQ-030 NR50/NR51/NR52 addresses SHALL live in the shared memory-definition header alongside the other NRxx defines; FSM state encodings and the 20-bit sample width SHALL be in a shared sound constants file.
REQ-031 The accumulate/scale datapath SHALL be one sub-module, sound_mix_path, instantiated twice (left, right) under the single FSM.

Verification
REQ-032 Reset, write NR52=8'h80, read NR52 with CH3_ON=1 -> read value 8'hF4.
REQ-033 NR51=8'h11, NR50=8'h77, CH1=20'h7FFFF, others 0, strobe -> at strobe+6 L=R=20'h1FFFF, valid for 1 cycle.
REQ-034 All four channels at 20'h7FFFF, NR51=8'hF0, NR50=8'h70 -> L=20'h7FFFF, R=0.
REQ-035 NR50=8'h30 (VL=3), NR51=8'h10, CH1=20'h44443 -> L=20'h08888; second strobe 2 cycles after the first -> ignored, exactly one valid pulse.
REQ-036 Mid-mix (ACC2), write NR52=8'h00 -> no valid pulse, outputs 0, NR50/NR51 read 0; assert I_RESET mid-mix -> FSM IDLE, all outputs 0 immediately.
